keylock_param: RTL and testbench

KEYLOCK_PARAM -- requirements
Module: keylock_param

---
 rtl/keylock_param_if.sv | 13 +
 rtl/keylock_param.sv | 100 ++++++++++
 tb/tb_keylock_param.sv | 120 ++++++++++++
 3 files changed

// File: rtl/keylock_param_if.sv
// keylock_param_if: keypad strobe, control requests and lock status bundle.
interface keylock_param_if #(parameter int KEY_W = 4);
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             relock;
    logic             prog_en;
    logic             locked;
    logic             alarm;
    logic [3:0]       fail_cnt;
    logic             prog_done;
    modport master (output key, key_valid, relock, prog_en, input locked, alarm, fail_cnt, prog_done);
    modport slave  (input key, key_valid, relock, prog_en, output locked, alarm, fail_cnt, prog_done);
endinterface

// File: rtl/keylock_param.sv
// keylock_param: digit-code lock with lockout after repeated failures, idle relock
// and in-field reprogramming of the stored code.
module keylock_param #(
    parameter int KEY_W = 4,
    parameter int CODE_LEN = 6,
    parameter logic [CODE_LEN*KEY_W-1:0] DEFAULT_CODE = 24'h335256,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter int RELOCK_CYC = 64
) (
    input logic clk,
    input logic reset_n,
    keylock_param_if.slave bus
);
    localparam logic [1:0] LOCKED = 2'd0, UNLOCKED = 2'd1, PROGRAM = 2'd2, LOCKOUT = 2'd3;
    localparam int DW = $clog2(CODE_LEN + 1);
    localparam int TMAX = LOCKOUT_CYC > RELOCK_CYC ? LOCKOUT_CYC : RELOCK_CYC;
    localparam int TW = $clog2(TMAX + 1);
    localparam int CW = CODE_LEN * KEY_W;
    logic [1:0] state;
    logic [DW-1:0] digit_cnt;
    logic [TW-1:0] tmr;
    logic [3:0] fail_cnt, fail_inc;
    logic prog_done;
    logic [CW-1:0] code, dig_buf, dig_nxt;
    logic last;
    // dig_buf holds entered digits in LOCKED and the shadow code in PROGRAM
    always_comb begin
        dig_nxt = dig_buf;
        for (int i = 0; i < CODE_LEN; i++)
            if (digit_cnt == DW'(i)) dig_nxt[(CODE_LEN-1-i)*KEY_W +: KEY_W] = bus.key;
    end
    assign last = digit_cnt == DW'(CODE_LEN - 1);
    assign fail_inc = fail_cnt == 4'hF ? fail_cnt : fail_cnt + 4'd1;
    assign bus.locked = !(state == UNLOCKED || state == PROGRAM);
    assign bus.alarm = state == LOCKOUT;
    assign bus.fail_cnt = fail_cnt;
    assign bus.prog_done = prog_done;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOCKED;
            digit_cnt <= '0;
            tmr <= '0;
            fail_cnt <= '0;
            prog_done <= 1'b0;
            code <= DEFAULT_CODE;
            dig_buf <= '0;
        end else begin
            prog_done <= 1'b0;
            case (state)
                LOCKED: if (bus.key_valid) begin
                    dig_buf <= dig_nxt;
                    digit_cnt <= last ? '0 : digit_cnt + 1'b1;
                    if (last && dig_nxt == code) begin
                        state <= UNLOCKED;
                        fail_cnt <= '0;
                        tmr <= TW'(RELOCK_CYC);
                    end else if (last) begin
                        fail_cnt <= fail_inc;
                        if (fail_inc == 4'(MAX_FAIL)) begin
                            state <= LOCKOUT;
                            tmr <= TW'(LOCKOUT_CYC);
                        end
                    end
                end
                UNLOCKED: begin
                    digit_cnt <= '0;
                    if (bus.relock) state <= LOCKED;
                    else if (bus.prog_en) state <= PROGRAM;
                    else if (bus.key_valid) tmr <= TW'(RELOCK_CYC);
                    else if (tmr <= TW'(1)) state <= LOCKED;
                    else tmr <= tmr - 1'b1;
                end
                PROGRAM: begin
                    if (bus.relock || !bus.prog_en) begin
                        state <= bus.relock ? LOCKED : UNLOCKED;
                        digit_cnt <= '0;
                        tmr <= TW'(RELOCK_CYC);
                    end else if (bus.key_valid) begin
                        dig_buf <= dig_nxt;
                        digit_cnt <= last ? '0 : digit_cnt + 1'b1;
                        if (last) begin
                            code <= dig_nxt;
                            prog_done <= 1'b1;
                            state <= UNLOCKED;
                            tmr <= TW'(RELOCK_CYC);
                        end
                    end
                end
                LOCKOUT: if (tmr <= TW'(1)) begin
                    state <= LOCKED;
                    fail_cnt <= '0;
                    digit_cnt <= '0;
                    tmr <= '0;
                end else tmr <= tmr - 1'b1;
                default: state <= LOCKED;
            endcase
        end
    end
endmodule

// File: tb/tb_keylock_param.sv
// tb_keylock_param: directed checks of unlock, failure/lockout, programming,
// aborts, idle relock and asynchronous reset.
module tb_keylock_param;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0, errors = 0, alarm_cyc = 0, pd_cnt = 0;
    keylock_param_if #(.KEY_W(4)) bus ();
    keylock_param dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.alarm) alarm_cyc++;
        if (bus.prog_done) pd_cnt++;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        bus.key = d;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask
    task automatic enter(input logic [23:0] c);
        for (int i = 5; i >= 0; i--) press(c[i*4 +: 4]);
    endtask
    task automatic do_relock();
        @(negedge clk);
        bus.relock = 1'b1;
        @(negedge clk);
        bus.relock = 1'b0;
    endtask
    initial begin
        bus.key = '0;
        bus.key_valid = 1'b0;
        bus.relock = 1'b0;
        bus.prog_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_locked", bus.locked, 1);
        chk("rst_alarm", bus.alarm, 0);
        chk("rst_fail", bus.fail_cnt, 0);
        chk("rst_pdone", bus.prog_done, 0);
        reset_n = 1'b1;
        enter(24'h335256);
        chk("ok_locked", bus.locked, 0);
        chk("ok_fail", bus.fail_cnt, 0);
        do_relock();
        chk("relock", bus.locked, 1);
        enter(24'h335257);
        chk("bad_locked", bus.locked, 1);
        chk("bad_fail", bus.fail_cnt, 1);
        press(4'h3); press(4'h3); press(4'h4); press(4'h0); press(4'h0);
        chk("no_early_abort", bus.fail_cnt, 1);
        press(4'h0);
        chk("bad2_fail", bus.fail_cnt, 2);
        alarm_cyc = 0;
        enter(24'h000000);
        chk("lockout_alarm", bus.alarm, 1);
        chk("lockout_fail", bus.fail_cnt, 3);
        enter(24'h335256);
        for (int i = 0; i < 40 && bus.alarm; i++) @(negedge clk);
        chk("lockout_len", alarm_cyc, 16);
        chk("post_lock_alarm", bus.alarm, 0);
        chk("post_lock_fail", bus.fail_cnt, 0);
        chk("ignored_in_lockout", bus.locked, 1);
        enter(24'h335256);
        chk("post_lock_unlock", bus.locked, 0);
        pd_cnt = 0;
        @(negedge clk) bus.prog_en = 1'b1;
        enter(24'h123456);
        chk("prog_done", bus.prog_done, 1);
        bus.prog_en = 1'b0;
        @(negedge clk);
        chk("prog_done_once", pd_cnt, 1);
        chk("prog_unlocked", bus.locked, 0);
        do_relock();
        enter(24'h335256);
        chk("old_code_fails", bus.locked, 1);
        enter(24'h123456);
        chk("new_code_unlocks", bus.locked, 0);
        @(negedge clk) bus.prog_en = 1'b1;
        press(4'h7); press(4'h7); press(4'h7);
        bus.prog_en = 1'b0;
        @(negedge clk);
        chk("abort_unlocked", bus.locked, 0);
        do_relock();
        enter(24'h123456);
        chk("abort_code_kept", bus.locked, 0);
        @(negedge clk) bus.prog_en = 1'b1;
        press(4'h8); press(4'h8);
        do_relock();
        bus.prog_en = 1'b0;
        chk("prog_relock", bus.locked, 1);
        enter(24'h123456);
        chk("relock_code_kept", bus.locked, 0);
        repeat (63) @(negedge clk);
        chk("idle_63", bus.locked, 0);
        @(negedge clk);
        chk("idle_64", bus.locked, 1);
        enter(24'h123456);
        @(negedge clk) bus.prog_en = 1'b1;
        press(4'h9); press(4'h9);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_locked", bus.locked, 1);
        chk("async_rst_fail", bus.fail_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.prog_en = 1'b0;
        enter(24'h123456);
        chk("rst_prog_code_gone", bus.locked, 1);
        enter(24'h335256);
        chk("default_restored", bus.locked, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
